// File: rtl/object_scan_renderer_if.sv
// Pixel-stream, sprite-ROM and result-stream signals of the object scan renderer.
// The renderer uses the slave modport; the pixel source / ROM / compositor side uses master.
interface object_scan_renderer_if #(
    parameter int XLEN    = 10,
    parameter int YLEN    = 10,
    parameter int ADDR_W  = 18,
    parameter int COLOR_W = 12
) ();
    logic               pix_valid;
    logic [XLEN-1:0]    pix_x;
    logic [YLEN-1:0]    pix_y;
    logic               rom_en;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_data;
    logic               out_valid;
    logic               out_hit;
    logic [COLOR_W-1:0] out_color;

    modport slave (
        input  pix_valid, pix_x, pix_y, rom_data,
        output rom_en, rom_addr, out_valid, out_hit, out_color
    );

    modport master (
        output pix_valid, pix_x, pix_y, rom_data,
        input  rom_en, rom_addr, out_valid, out_hit, out_color
    );
endinterface

// File: rtl/object_scan_renderer.sv
// Per-object scan renderer: box test, sprite-ROM read and colour/hit stream, latency 3.
// Optional OBJ_MIRROR_EN: descriptor MSB flips the sprite horizontally.
module object_scan_renderer #(
    parameter int DATA_LEN = 48,
    parameter int XLEN     = 10,
    parameter int YLEN     = 10,
    parameter int MAX_W    = 64,
    parameter int MAX_H    = 64,
    parameter int ADDR_W   = 18,
    parameter int COLOR_W  = 12,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 12'hF0F
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic [DATA_LEN-1:0] obj_in,
    object_scan_renderer_if.slave bus
);
    // Descriptor layout, LSB first: x, y, width, height, type; MSB is the mirror flag.
    localparam int SZ_LEN = 8;
    localparam int X_LSB  = 0;
    localparam int Y_LSB  = X_LSB + XLEN;
    localparam int W_LSB  = Y_LSB + YLEN;
    localparam int H_LSB  = W_LSB + SZ_LEN;
    localparam int T_LSB  = H_LSB + SZ_LEN;
    localparam int T_LEN  = DATA_LEN - 1 - T_LSB;
    localparam int LOG_W  = $clog2(MAX_W);
    localparam int LOG_H  = $clog2(MAX_H);
    localparam int W_BITS = LOG_W + 1;
    localparam int H_BITS = LOG_H + 1;

    logic [XLEN-1:0]    x_q, x_d;
    logic [YLEN-1:0]    y_q, y_d;
    logic [W_BITS-1:0]  w_q, w_d;
    logic [H_BITS-1:0]  h_q, h_d;
    logic [T_LEN-1:0]   type_q, type_d;
    logic               mirror_q, mirror_d;

    logic               v1_q, v1_d;
    logic               in_box_q, in_box_d;
    logic [LOG_W-1:0]   col_q, col_d;
    logic [LOG_H-1:0]   row_q, row_d;
    logic [T_LEN-1:0]   type1_q, type1_d;

    logic               v2_q, v2_d;
    logic               rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;

    logic               out_valid_q, out_valid_d;
    logic               out_hit_q, out_hit_d;
    logic [COLOR_W-1:0] out_color_q, out_color_d;

    logic [XLEN:0]      dx_full;
    logic [YLEN:0]      dy_full;
    logic [SZ_LEN-1:0]  obj_w, obj_h;

    always_comb begin
        obj_w = obj_in[W_LSB +: SZ_LEN];
        obj_h = obj_in[H_LSB +: SZ_LEN];

        x_d      = x_q;
        y_d      = y_q;
        w_d      = w_q;
        h_d      = h_q;
        type_d   = type_q;
        mirror_d = mirror_q;
        if (frame_start) begin
            x_d    = obj_in[X_LSB +: XLEN];
            y_d    = obj_in[Y_LSB +: YLEN];
            w_d    = (obj_w > SZ_LEN'(MAX_W)) ? W_BITS'(MAX_W) : W_BITS'(obj_w);
            h_d    = (obj_h > SZ_LEN'(MAX_H)) ? H_BITS'(MAX_H) : H_BITS'(obj_h);
            type_d = obj_in[T_LSB +: T_LEN];
`ifdef OBJ_MIRROR_EN
            mirror_d = obj_in[DATA_LEN-1];
`else
            mirror_d = 1'b0;
`endif
        end

        // Subtract-then-compare so an object hanging past the screen edge never wraps.
        dx_full  = {1'b0, bus.pix_x} - {1'b0, x_q};
        dy_full  = {1'b0, bus.pix_y} - {1'b0, y_q};
        v1_d     = bus.pix_valid;
        in_box_d = bus.pix_valid
                 & (bus.pix_x >= x_q) & (dx_full < (XLEN+1)'(w_q))
                 & (bus.pix_y >= y_q) & (dy_full < (YLEN+1)'(h_q));
        row_d    = dy_full[LOG_H-1:0];
        col_d    = dx_full[LOG_W-1:0];
        if (mirror_q) begin
            col_d = LOG_W'(w_q - W_BITS'(1)) - dx_full[LOG_W-1:0];
        end
        // Type travels with the pixel so a mid-pipeline reload cannot retarget it.
        type1_d  = type_q;

        v2_d       = v1_q;
        rom_en_d   = v1_q & in_box_q;
        rom_addr_d = rom_addr_q;
        if (rom_en_d) begin
            rom_addr_d = (ADDR_W'(type1_q) << (LOG_W + LOG_H))
                       + (ADDR_W'(row_q) << LOG_W)
                       + ADDR_W'(col_q);
        end

        // rom_en_q doubles as the stage-2 hit flag; rom_data belongs to that read.
        out_valid_d = v2_q;
        out_hit_d   = rom_en_q & (bus.rom_data != TRANSPARENT);
        out_color_d = out_hit_d ? bus.rom_data : '0;
    end

`ifndef OBJ_MIRROR_EN
    logic unused_mirror_bit;
    assign unused_mirror_bit = obj_in[DATA_LEN-1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            type_q      <= '0;
            mirror_q    <= 1'b0;
            v1_q        <= 1'b0;
            in_box_q    <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            type1_q     <= '0;
            v2_q        <= 1'b0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_color_q <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            type_q      <= type_d;
            mirror_q    <= mirror_d;
            v1_q        <= v1_d;
            in_box_q    <= in_box_d;
            col_q       <= col_d;
            row_q       <= row_d;
            type1_q     <= type1_d;
            v2_q        <= v2_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            out_color_q <= out_color_d;
        end
    end

    assign bus.rom_en    = rom_en_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_hit   = out_hit_q;
    assign bus.out_color = out_color_q;
endmodule

// File: tb/tb_object_scan_renderer.sv
// Directed bench for object_scan_renderer: transaction model keyed by clock edge plus literal pins.
module tb_object_scan_renderer;
    localparam int NE = 512;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [47:0] obj_in;

    object_scan_renderer_if #(.XLEN(10), .YLEN(10), .ADDR_W(18), .COLOR_W(12)) bus ();

    object_scan_renderer dut (
        .clk         (clk),
        .reset       (rst),
        .frame_start (frame_start),
        .obj_in      (obj_in),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] rom_func(input logic [17:0] a);
        if (a == 18'd12615) return 12'hF0F;
        return 12'((int'(a) * 5 + 3) % 4096);
    endfunction

    // Sprite ROM: data for the address currently being read.
    assign bus.rom_data = bus.rom_en ? rom_func(bus.rom_addr) : 12'h555;

    function automatic logic [47:0] mk_obj(input int t, input int h, input int w,
                                          input int y, input int x, input bit mir);
        return {mir, 11'(t), 8'(h), 8'(w), 10'(y), 10'(x)};
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Expected results indexed by the clock edge after which they are visible.
    int edge_n = 0;
    bit rst_at [NE];
    bit exp_en [NE];
    int exp_addr [NE];
    bit exp_ov [NE];
    bit exp_oh [NE];
    int exp_oc [NE];
    int obs_en [NE];
    int obs_addr [NE];
    int obs_ov [NE];
    int obs_oh [NE];
    int obs_oc [NE];

    int sx = 0, sy = 0, sw = 0, sh = 0, st = 0;
    bit smir = 0;
`ifdef OBJ_MIRROR_EN
    localparam bit MIRROR_ON = 1'b1;
`else
    localparam bit MIRROR_ON = 1'b0;
`endif

    always @(posedge clk) begin
        int e, px, py, dx, dy, col, addr, c;
        bit inbox;
        e = edge_n;
        if (e + 2 < NE) begin
            if (rst) begin
                rst_at[e] = 1;
                exp_en[e] = 0; exp_en[e+1] = 0;
                for (int k = 0; k < 3; k++) begin
                    exp_ov[e+k] = 0; exp_oh[e+k] = 0; exp_oc[e+k] = 0;
                end
                sx = 0; sy = 0; sw = 0; sh = 0; st = 0; smir = 0;
            end else begin
                if (bus.pix_valid) begin
                    px = int'(bus.pix_x);
                    py = int'(bus.pix_y);
                    dx = px - sx;
                    dy = py - sy;
                    inbox = (px >= sx) && (dx < sw) && (py >= sy) && (dy < sh);
                    col = (MIRROR_ON && smir) ? (sw - 1 - dx) : dx;
                    addr = (st * 4096 + dy * 64 + col) % 262144;
                    c = int'(rom_func(18'(addr)));
                    exp_en[e+1]   = inbox;
                    exp_addr[e+1] = addr;
                    exp_ov[e+2]   = 1;
                    exp_oh[e+2]   = inbox && (c != 'hF0F);
                    exp_oc[e+2]   = (inbox && (c != 'hF0F)) ? c : 0;
                end else begin
                    exp_en[e+1] = 0;
                    exp_ov[e+2] = 0; exp_oh[e+2] = 0; exp_oc[e+2] = 0;
                end
                if (frame_start) begin
                    sx = int'(obj_in[9:0]);
                    sy = int'(obj_in[19:10]);
                    sw = int'(obj_in[27:20]); if (sw > 64) sw = 64;
                    sh = int'(obj_in[35:28]); if (sh > 64) sh = 64;
                    st = int'(obj_in[46:36]);
                    smir = obj_in[47];
                end
            end
        end
        edge_n = e + 1;
    end

    // Compare process: every cycle, all outputs against the model.
    int held_addr = 0;
    always @(negedge clk) begin
        int k;
        if (edge_n > 0 && edge_n < NE) begin
            k = edge_n - 1;
            if (rst_at[k]) held_addr = 0;
            else if (exp_en[k]) held_addr = exp_addr[k];
            obs_en[k]   = int'(bus.rom_en);
            obs_addr[k] = int'(bus.rom_addr);
            obs_ov[k]   = int'(bus.out_valid);
            obs_oh[k]   = int'(bus.out_hit);
            obs_oc[k]   = int'(bus.out_color);
            check($sformatf("rom_en@%0d", k),    obs_en[k],   int'(exp_en[k]));
            check($sformatf("rom_addr@%0d", k),  obs_addr[k], held_addr);
            check($sformatf("out_valid@%0d", k), obs_ov[k],   int'(exp_ov[k]));
            check($sformatf("out_hit@%0d", k),   obs_oh[k],   int'(exp_oh[k]));
            check($sformatf("out_color@%0d", k), obs_oc[k],   exp_oc[k]);
        end
    end

    localparam logic [47:0] JUNK = 48'hDEAD_BEEF_1234;

    task automatic drive(input bit r, input bit fs, input logic [47:0] obj,
                         input bit pv, input int x, input int y, output int e);
        @(negedge clk);
        rst = r;
        frame_start = fs;
        obj_in = obj;
        bus.pix_valid = pv;
        bus.pix_x = 10'(x);
        bus.pix_y = 10'(y);
        e = edge_n;
    endtask

    task automatic px(input int x, input int y, output int e);
        drive(0, 0, JUNK, 1, x, y, e);
    endtask

    int e1, e2, e3, e4, e5, e6, et3, e4a, e4b, e4c, erst, ew0, ewr;
    logic [47:0] t1_obj;

    initial begin
        rst = 1; frame_start = 0; obj_in = '0;
        bus.pix_valid = 0; bus.pix_x = '0; bus.pix_y = '0;
        t1_obj = mk_obj(3, 44, 40, 200, 100, 0);

        for (int i = 0; i < 3; i++) drive(1, 1, t1_obj, 1, 100, 200, e1);
        px(5, 5, ew0);
        drive(0, 1, t1_obj, 0, 0, 0, e1);
        px(100, 200, e1);
        px(139, 243, e2);
        px(140, 200, e3);
        px(100, 244, e4);
        px(99, 200, e5);
        px(100, 199, e5);
        drive(0, 0, JUNK, 0, 110, 210, e5);
        px(107, 205, et3);
        px(120, 220, e5);

        drive(0, 1, mk_obj(1, 10, 100, 0, 0, 0), 1, 100, 200, e4a);
        px(100, 200, e4b);
        px(5, 3, e4c);
        px(63, 9, e5);
        px(64, 9, e5);

        drive(0, 1, mk_obj(2, 64, 64, 1000, 1000, 0), 0, 0, 0, e5);
        px(1023, 1023, ewr);
        px(10, 1000, e5);
        px(1000, 10, e5);
        px(1000, 1000, e5);

        drive(0, 1, mk_obj(5, 20, 0, 0, 0, 0), 0, 0, 0, e5);
        px(0, 0, e5);

        drive(0, 1, t1_obj, 0, 0, 0, e5);
        px(100, 200, e5);
        px(101, 201, e5);
        px(102, 202, e5);
        drive(1, 0, JUNK, 1, 103, 203, erst);
        px(100, 200, e5);
        px(0, 0, e5);
        px(1, 1, e5);

        drive(0, 1, mk_obj(3, 44, 40, 200, 100, 1), 0, 0, 0, e5);
        px(100, 200, e6);
        px(139, 200, e5);
        for (int i = 0; i < 4; i++) drive(0, 0, JUNK, 0, 0, 0, e5);

        // Hand-computed pins
        check("reset_out_valid", obs_ov[1], 0);
        check("w0_no_hit", obs_en[ew0 + 1], 0);
        check("t1_rom_en", obs_en[e1 + 1], 1);
        check("t1_rom_addr", obs_addr[e1 + 1], 12288);
        check("t1_out_valid", obs_ov[e1 + 2], 1);
        check("t2_rom_addr", obs_addr[e2 + 1], 15079);
        check("t2_out_hit", obs_oh[e2 + 2], 1);
        check("t2_col_past", obs_en[e3 + 1], 0);
        check("t2_row_past", obs_oh[e4 + 2], 0);
        check("t3_valid", obs_ov[et3 + 2], 1);
        check("t3_hit", obs_oh[et3 + 2], 0);
        check("t3_color", obs_oc[et3 + 2], 0);
        check("t4_old_shadow", obs_addr[e4a + 1], 12288);
        check("t4_new_x_miss", obs_en[e4b + 1], 0);
        check("t4_new_addr", obs_addr[e4c + 1], 4293);
        check("wrap_edge_hit", obs_addr[ewr + 1], 2 * 4096 + 23 * 64 + 23);
        check("t5_reset_cycle", obs_ov[erst], 0);
        check("t5_reset_next", obs_ov[erst + 1], 0);
        check("t5_no_hit_after", obs_en[erst + 2], 0);
`ifdef OBJ_MIRROR_EN
        check("t6_mirror_addr", obs_addr[e6 + 1], 12327);
`else
        check("t6_mirror_addr", obs_addr[e6 + 1], 12288);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
